// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//
// Architectural constants shared by the integer register file and its
// scoreboard. These are the default values for the regfile_sb parameters;
// each module can still be overridden per instance.
//
//   XLEN     integer data width in bits
//   NREG     number of architectural registers (power of two, >= 4)
//   SP_IDX   index of the stack-pointer register
//   SP_INIT  value loaded into the stack pointer by reset
//   reg_idx_t  register index type, log2(NREG) bits
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREG    = 32;
  localparam int unsigned SP_IDX  = 2;
  localparam int unsigned SP_INIT = 1000;

  typedef logic [$clog2(NREG)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Pending-write tracker for the integer register file. One bit per
// architectural register records that an issued instruction will write it
// and the result has not yet come back through writeback.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   - busy for an operand drops in the same cycle its writeback
//               is presented (the data port forwards the value)
//   undefined - busy reflects the stored pending bit only, so it drops the
//               cycle after writeback
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset, clears every pending bit
//   issue_en   in   mark issue_rd pending
//   issue_rd   in   destination register of the issued instruction
//   wr_en      in   writeback strobe
//   wr_addr    in   writeback destination, clears its pending bit
//   flush      in   clear all pending bits, drops a same-cycle issue
//   rs1_addr   in   operand 1 register index
//   rs2_addr   in   operand 2 register index
//   rs1_busy   out  operand 1 still waiting for its producer
//   rs2_busy   out  operand 2 still waiting for its producer
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int unsigned NREG = cpu_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_en,
  input  logic [$clog2(NREG)-1:0] issue_rd,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic                    flush,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (wr_en && (wr_addr != '0)) begin
      pend_d[wr_addr] = 1'b0;
    end
    // Issue is applied after writeback so that an issue and a writeback to
    // the same register leave it pending: the issued instruction is the
    // newer producer. A flush squashes the issuing instruction as well.
    if (flush) begin
      pend_d = '0;
    end else if (issue_en && (issue_rd != '0)) begin
      pend_d[issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
      // Issuing to a register that is still pending means the issue logic
      // lost track of a WAW hazard.
      if (issue_en && (issue_rd != '0)) begin
        assert (!pend_q[issue_rd]);
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A result arriving this cycle is forwarded, so the operand is ready now.
  assign rs1_busy = (rs1_addr != '0) && pend_q[rs1_addr] &&
                    !(wr_en && (wr_addr == rs1_addr));
  assign rs2_busy = (rs2_addr != '0) && pend_q[rs2_addr] &&
                    !(wr_en && (wr_addr == rs2_addr));
`else
  assign rs1_busy = (rs1_addr != '0) && pend_q[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) && pend_q[rs2_addr];
`endif

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Integer register file with an integrated pending-write scoreboard for the
// decode stage: two combinational read ports with per-operand busy flags,
// one writeback port, an issue port that marks destinations pending, a
// flush, and a debug read port. Register 0 is hard-wired to zero and is
// never busy. Reset zeroes the file, presets the stack pointer to SP_INIT
// and clears the scoreboard.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   - a writeback is forwarded to rs1_data/rs2_data in the same
//               cycle and the matching busy flag drops in that cycle
//   undefined - read ports show the stored value only; the write becomes
//               visible the following cycle
//   The debug port never forwards.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset, overrides every strobe
//   rs1_addr   in   read address, port 1
//   rs2_addr   in   read address, port 2
//   rs1_data   out  read data, port 1 (combinational)
//   rs2_data   out  read data, port 2 (combinational)
//   rs1_busy   out  port 1 operand has an outstanding producer
//   rs2_busy   out  port 2 operand has an outstanding producer
//   issue_en   in   mark issue_rd pending
//   issue_rd   in   destination of the issued instruction
//   wr_en      in   writeback strobe
//   wr_addr    in   writeback destination
//   wr_data    in   writeback data
//   flush      in   clear all pending bits (pipeline squash)
//   dbg_addr   in   debug read address
//   dbg_data   out  debug read data (combinational, stored value only)
// -----------------------------------------------------------------------------
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN    = cpu_pkg::XLEN,
  parameter int unsigned     NREG    = cpu_pkg::NREG,
  parameter int unsigned     SP_IDX  = cpu_pkg::SP_IDX,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(cpu_pkg::SP_INIT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  input  logic                    issue_en,
  input  logic [$clog2(NREG)-1:0] issue_rd,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic                    flush,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [XLEN-1:0]         dbg_data
);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];

  logic [XLEN-1:0] rd1_stored;
  logic [XLEN-1:0] rd2_stored;

  // Register 0 is never written, so its slot simply holds the reset zero.
  always_comb begin
    rf_d = rf_q;
    if (wr_en && (wr_addr != '0)) begin
      rf_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Address 0 is masked on every read so x0 is zero even before the first
  // reset.
  assign rd1_stored = (rs1_addr == '0) ? '0 : rf_q[rs1_addr];
  assign rd2_stored = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];
  assign dbg_data   = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

`ifdef REGFILE_BYPASS_EN
  assign rs1_data = (wr_en && (rs1_addr != '0) && (wr_addr == rs1_addr)) ?
                    wr_data : rd1_stored;
  assign rs2_data = (wr_en && (rs2_addr != '0) && (wr_addr == rs2_addr)) ?
                    wr_data : rd2_stored;
`else
  assign rs1_data = rd1_stored;
  assign rs2_data = rd2_stored;
`endif

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//
// Directed scenarios followed by randomized traffic for regfile_sb, checked
// against an array-based architectural model of the register file and its
// pending bits. Expected read/busy values account for REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int NREG = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flush;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .flush    (flush),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Architectural model: register contents and outstanding producers.
  logic [31:0] m_rf [NREG];
  bit          m_pend [NREG];
  bit          m_valid = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && wr_en && (wr_addr == a)) return wr_data;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (BYP && wr_en && (wr_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic [31:0] exp_dbg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    return m_rf[a];
  endfunction

  task automatic idle();
    rst      = 1'b0;
    issue_en = 1'b0;
    issue_rd = 5'd0;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'd0;
    flush    = 1'b0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    dbg_addr = 5'd0;
  endtask

  // Check the combinational outputs for the inputs currently applied, then
  // let one clock edge pass and advance the model by the same inputs.
  task automatic cycle(input string tag);
    @(negedge clk);
    #1;
    if (m_valid) begin
      check_val({tag, ".rs1_data"}, rs1_data, exp_rd(rs1_addr));
      check_val({tag, ".rs2_data"}, rs2_data, exp_rd(rs2_addr));
      check_val({tag, ".rs1_busy"}, {31'd0, rs1_busy}, {31'd0, exp_busy(rs1_addr)});
      check_val({tag, ".rs2_busy"}, {31'd0, rs2_busy}, {31'd0, exp_busy(rs2_addr)});
      check_val({tag, ".dbg_data"}, dbg_data, exp_dbg(dbg_addr));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_rf[i]   = 32'd0;
        m_pend[i] = 1'b0;
      end
      m_rf[2] = 32'd1000;
      m_valid = 1'b1;
    end else begin
      if (wr_en && (wr_addr != 5'd0)) begin
        m_rf[wr_addr]   = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      end else if (issue_en && (issue_rd != 5'd0)) begin
        m_pend[issue_rd] = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    idle();

    // Reset, then sweep every index on the debug and read ports.
    rst = 1'b1;
    cycle("reset");
    idle();
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = 5'(i);
      rs1_addr = 5'(i);
      rs2_addr = 5'(NREG - 1 - i);
      cycle("rst_sweep");
    end
    dbg_addr = 5'd2;
    #1;
    check_val("sp_reset", dbg_data, 32'd1000);

    // Write x5 with a same-cycle read, then read it back.
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rs1_addr = 5'd5; dbg_addr = 5'd5;
    cycle("wr_x5");
    idle();
    rs1_addr = 5'd5; dbg_addr = 5'd5;
    cycle("rd_x5");

    // x0 ignores writes and issues.
    idle();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    issue_en = 1'b1; issue_rd = 5'd0;
    cycle("x0_wr");
    idle();
    cycle("x0_rd");

    // Issue x7, observe busy, write it back.
    idle();
    issue_en = 1'b1; issue_rd = 5'd7; rs2_addr = 5'd7;
    cycle("iss_x7");
    idle();
    rs2_addr = 5'd7;
    cycle("busy_x7");
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd42; rs2_addr = 5'd7;
    cycle("wb_x7");
    idle();
    rs2_addr = 5'd7; dbg_addr = 5'd7;
    cycle("done_x7");

    // Issue and writeback to x9 together, then flush.
    idle();
    issue_en = 1'b1; issue_rd = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd7; rs1_addr = 5'd9;
    cycle("iss_wb_x9");
    idle();
    rs1_addr = 5'd9;
    cycle("held_x9");
    flush = 1'b1; rs1_addr = 5'd9;
    cycle("flush_x9");
    idle();
    rs1_addr = 5'd9; dbg_addr = 5'd9;
    cycle("post_flush_x9");

    // Issue dropped by a same-cycle flush.
    issue_en = 1'b1; issue_rd = 5'd10; flush = 1'b1;
    cycle("iss_flush_x10");
    idle();
    rs1_addr = 5'd10;
    cycle("dropped_x10");

    // Reset while a writeback and an issue are presented.
    idle();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd9;
    cycle("wr_x3");
    idle();
    issue_en = 1'b1; issue_rd = 5'd4;
    cycle("iss_x4");
    idle();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd5;
    issue_en = 1'b1; issue_rd = 5'd6; flush = 1'b1;
    rs1_addr = 5'd3; rs2_addr = 5'd4;
    cycle("rst_midop");
    idle();
    rs1_addr = 5'd3; rs2_addr = 5'd4; dbg_addr = 5'd3;
    cycle("after_rst_a");
    rs1_addr = 5'd6; rs2_addr = 5'd2; dbg_addr = 5'd2;
    cycle("after_rst_b");

    // Randomized traffic with frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 15));
      wr_data  = $urandom;
      issue_rd = 5'($urandom_range(0, 15));
      issue_en = ($urandom_range(0, 1) == 1) && !m_pend[issue_rd];
      rs1_addr = ($urandom_range(0, 2) == 0) ? wr_addr  : 5'($urandom_range(0, 15));
      rs2_addr = ($urandom_range(0, 2) == 0) ? issue_rd : 5'($urandom_range(0, 31));
      dbg_addr = ($urandom_range(0, 3) == 0) ? wr_addr  : 5'($urandom_range(0, 31));
      cycle("rand");
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
